// File: rtl/button_event_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : button_event_gen_pkg                                           |
// | Brief   : State encodings and default board timing for button_event_gen  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_HELD   = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  // Defaults assume a 50 MHz board clock: 1 s to long-press, 200 ms repeat.
  localparam int c_DEF_LONG_CYCLES   = 50_000_000;
  localparam int c_DEF_REPEAT_CYCLES = 10_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : button_event_gen                                               |
// | Brief   : Debounced button level -> press/release/long/step pulses       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int LONG_CYCLES   = c_DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = c_DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_state,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic step_pulse,
  output logic held
);

  localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] c_LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             r_release;
  logic             r_long;
  logic             r_step;
  logic             r_held;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ARM;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_step    <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_step    <= 1'b0;
      case (r_state)
        // A button already down when reset lifts must be let go first.
        ST_ARM: begin
          if (!pb_state) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (pb_state) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
            r_press <= 1'b1;
            r_step  <= 1'b1;
            r_held  <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!pb_state) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_held    <= 1'b0;
          end else if (r_cnt == c_LONG_LAST) begin
            r_state <= ST_REPEAT;
            r_cnt   <= '0;
            r_long  <= 1'b1;
            r_step  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!pb_state) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_held    <= 1'b0;
          end else if (!repeat_en) begin
            r_cnt <= '0;
          end else if (r_cnt == c_REPEAT_LAST) begin
            r_cnt  <= '0;
            r_step <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_ARM;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;
  assign step_pulse    = r_step;
  assign held          = r_held;

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_button_event_gen                                            |
// | Brief   : Directed vector table plus randomized run against a model      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_button_event_gen;

  localparam int LONG   = 8;
  localparam int REPEAT = 3;

  // Expected/observed outputs packed as {press, release, long, step, held}.
  localparam logic [4:0] c_NONE = 5'b00000;
  localparam logic [4:0] c_PRES = 5'b10011;
  localparam logic [4:0] c_HOLD = 5'b00001;
  localparam logic [4:0] c_LONG = 5'b00111;
  localparam logic [4:0] c_STEP = 5'b00011;
  localparam logic [4:0] c_REL  = 5'b01000;

  typedef struct {
    logic       rst;
    logic       pb;
    logic       en;
    logic [4:0] exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb_state = 1'b0;
  logic repeat_en = 1'b0;
  logic press_pulse, release_pulse, long_pulse, step_pulse, held;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  // Reference model: time-stamp view of a press rather than a state machine.
  bit m_seen_low;
  bit m_down;
  bit m_long_done;
  int m_now;
  int m_t_press;
  int m_en_run;

  button_event_gen #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REPEAT)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .pb_state     (pb_state),
    .repeat_en    (repeat_en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .step_pulse   (step_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] observed();
    return {press_pulse, release_pulse, long_pulse, step_pulse, held};
  endfunction

  task automatic add(input logic r, input logic p, input logic e,
                     input logic [4:0] x, input string nm);
    vec_t v;
    v.rst = r; v.pb = p; v.en = e; v.exp = x; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic apply_check(input logic r, input logic p, input logic e,
                             input logic [4:0] x, input string nm);
    @(negedge clk);
    rst = r; pb_state = p; repeat_en = e;
    @(posedge clk);
    #1;
    n_vec++;
    if (observed() !== x) begin
      n_bad++;
      $display("FAIL %s vec %0d: got {prs,rel,lng,stp,hld}=%b expected %b",
               nm, n_vec, observed(), x);
    end
  endtask

  function automatic logic [4:0] model_step(input logic r, input logic p, input logic e);
    logic [4:0] o;
    o = c_NONE;
    m_now++;
    if (r) begin
      m_seen_low = 0; m_down = 0; m_long_done = 0; m_en_run = 0;
    end else if (!m_seen_low) begin
      if (!p) m_seen_low = 1;
    end else if (!m_down) begin
      if (p) begin
        m_down = 1; m_t_press = m_now; m_long_done = 0; m_en_run = 0;
        o[4] = 1'b1; o[1] = 1'b1;
      end
    end else if (!p) begin
      m_down = 0;
      o[3] = 1'b1;
    end else if (!m_long_done) begin
      if (m_now - m_t_press == LONG) begin
        m_long_done = 1; m_en_run = 0;
        o[2] = 1'b1; o[1] = 1'b1;
      end
    end else if (e) begin
      m_en_run++;
      if (m_en_run == REPEAT) begin
        m_en_run = 0;
        o[1] = 1'b1;
      end
    end else begin
      m_en_run = 0;
    end
    o[0] = m_down;
    return o;
  endfunction

  initial begin
    // 1: button held through reset, then released and re-pressed
    for (int k = 0; k < 10; k++) add(1, 1, 0, c_NONE, "rst_held");
    for (int k = 0; k < 3; k++)  add(0, 1, 0, c_NONE, "arm_no_press");
    for (int k = 0; k < 2; k++)  add(0, 0, 0, c_NONE, "arm_low");
    add(0, 1, 0, c_PRES, "first_press");
    add(0, 1, 0, c_HOLD, "first_hold");
    add(0, 0, 0, c_REL,  "first_release");
    add(0, 0, 0, c_NONE, "idle");
    // 2: short press
    add(0, 1, 0, c_PRES, "short_press");
    add(0, 1, 0, c_HOLD, "short_hold");
    add(0, 1, 0, c_HOLD, "short_hold");
    add(0, 0, 0, c_REL,  "short_release");
    add(0, 0, 1, c_NONE, "idle");
    // 3: long press with auto-repeat
    for (int k = 0; k < 20; k++)
      add(0, 1, 1, (k == 0) ? c_PRES : (k == 8) ? c_LONG :
                   (k == 11 || k == 14 || k == 17) ? c_STEP : c_HOLD, "repeat_run");
    add(0, 0, 1, c_REL,  "repeat_release");
    add(0, 0, 1, c_NONE, "idle");
    // 4: release on the long-press edge wins
    for (int k = 0; k < 8; k++) add(0, 1, 1, (k == 0) ? c_PRES : c_HOLD, "boundary_hold");
    add(0, 0, 1, c_REL,  "boundary_release");
    add(0, 0, 0, c_NONE, "idle");
    // 5: repeat disabled, then enabled at E12
    for (int k = 0; k < 19; k++)
      add(0, 1, (k >= 12), (k == 0) ? c_PRES : (k == 8) ? c_LONG :
                           (k == 14 || k == 17) ? c_STEP : c_HOLD, "repeat_gate");
    add(0, 0, 1, c_REL,  "gate_release");
    add(0, 0, 1, c_NONE, "idle");
    // 6: reset in REPEAT with button still down
    for (int k = 0; k < 10; k++)
      add(0, 1, 1, (k == 0) ? c_PRES : (k == 8) ? c_LONG : c_HOLD, "pre_reset_run");
    add(1, 1, 1, c_NONE, "reset_in_repeat");
    add(0, 1, 1, c_NONE, "rearm_wait");
    add(0, 1, 1, c_NONE, "rearm_wait");
    add(0, 0, 1, c_NONE, "rearm_low");
    add(0, 1, 1, c_PRES, "repress");
    add(0, 0, 1, c_REL,  "repress_release");

    foreach (tbl[i]) apply_check(tbl[i].rst, tbl[i].pb, tbl[i].en, tbl[i].exp, tbl[i].name);

    // Randomized phase: long/short holds, toggling repeat_en, rare resets.
    begin
      logic p, e, r;
      int   run;
      logic [4:0] x;
      m_now = 0;
      p = 1'b1; e = 1'b1; run = 0;
      x = model_step(1'b1, p, e);
      apply_check(1'b1, p, e, x, "rand_reset");
      for (int c = 0; c < 3000; c++) begin
        if (run == 0) begin
          p = ~p;
          run = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 9);
        end
        run--;
        if ($urandom_range(0, 15) == 0) e = ~e;
        r = ($urandom_range(0, 299) == 0);
        x = model_step(r, p, e);
        apply_check(r, p, e, x, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
